mem_bus_ctrl: RTL

Load/store memory controller sitting directly downstream of the multicycle core's address/write-data/MemWrite path. It replaces the bare combinational memory with a ready/valid request–response unit.
- Owns a word-addressed data RAM.
- Performs byte/half/word accesses with RV32I funct3 semantics and sign/zero extension.
- Inserts configurable wait states.
- Reports misaligned/out-of-range/illegal-width faults with a RISC-V mcause code for the control unit's trap path.

---
 rtl/mem_bus_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl -- ready/valid load/store controller with a private word RAM.
//
// Accepts one request in IDLE, spends the configured wait states in ACCESS,
// commits on the last ACCESS edge and pulses rsp_valid for one cycle in RESP.
// Requests that fail the width/alignment/range checks skip ACCESS and respond
// one cycle after accept with a RISC-V mcause code.
//
// Optional feature: define MEM_BUS_MMIO_EN to add led_out[7:0], an 8-bit
// register at byte address 0xFFFF_FFF0 (exempt from the range check).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1 = store, 0 = load
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   req_funct3            RV32I width code (B/H/W/BU/HU)
//   rsp_valid             one-cycle response pulse
//   rsp_rdata             extended load data, 0 for stores/faults, held
//   rsp_fault/rsp_cause   fault flag and mcause code, valid with rsp_valid
//   busy                  high in ACCESS or RESP
//   led_out               MMIO register (MEM_BUS_MMIO_EN only)
module mem_bus_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [3:0]  rsp_cause,
  output logic        busy
`ifdef MEM_BUS_MMIO_EN
  ,
  output logic [7:0]  led_out
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [2:0]      r_funct3;
  logic            r_mmio;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_fault;
  logic [3:0]      r_rsp_cause;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_req_mmio;
  logic            w_illegal;
  logic            w_misal;
  logic            w_oor;
  logic            w_fault;
  logic [3:0]      w_cause;
  logic            w_last;
  logic [31:0]     w_rword;
  logic [31:0]     w_lane;
  logic [31:0]     w_ext;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata_sh;
  logic            w_mem_we;

`ifdef MEM_BUS_MMIO_EN
  logic [7:0]      r_led;
  assign w_req_mmio = (req_addr[31:2] == 30'h3FFF_FFFC);
  assign led_out    = r_led;
`else
  assign w_req_mmio = 1'b0;
`endif

  // Accept-time fault check; the if/else chain encodes the priority.
  always_comb begin
    w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                (req_we && req_funct3[2]);
    w_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_oor     = !w_req_mmio && (32'(req_addr[31:2]) >= 32'(DEPTH_WORDS));
    w_fault   = w_illegal || w_misal || w_oor;
    if (w_illegal)   w_cause = 4'd2;
    else if (w_misal) w_cause = req_we ? 4'd6 : 4'd4;
    else if (w_oor)   w_cause = req_we ? 4'd7 : 4'd5;
    else              w_cause = 4'd0;
  end

  // r_cnt holds the ACCESS cycles still to run including the current one,
  // so ACCESS lasts WAIT_CYCLES cycles (at least one, since commit needs it).
  assign w_last = (r_cnt <= CW'(1));

`ifdef MEM_BUS_MMIO_EN
  assign w_rword = r_mmio ? {24'h0, r_led} : r_mem[r_addr[AW+1:2]];
`else
  assign w_rword = r_mem[r_addr[AW+1:2]];
`endif

  // Load lane select and extension; funct3[2] selects zero extension.
  always_comb begin
    w_lane = w_rword >> {r_addr[1:0], 3'b000};
    case (r_funct3[1:0])
      2'b00:   w_ext = {{24{w_lane[7]  & ~r_funct3[2]}}, w_lane[7:0]};
      2'b01:   w_ext = {{16{w_lane[15] & ~r_funct3[2]}}, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  // Store lane merge.
  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_be = 4'b0001 << r_addr[1:0];
      2'b01:   w_be = 4'b0011 << r_addr[1:0];
      default: w_be = 4'b1111;
    endcase
    w_wdata_sh = r_wdata << {r_addr[1:0], 3'b000};
  end

  // Gated by rst so a reset on the commit edge suppresses the write.
  assign w_mem_we = (r_state == S_ACCESS) && w_last && r_we && !r_mmio && !rst;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[r_addr[AW+1:2]][8*b +: 8] <= w_wdata_sh[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_mmio      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
      r_rsp_cause <= '0;
`ifdef MEM_BUS_MMIO_EN
      r_led       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_addr   <= req_addr[AW+1:0];
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            r_mmio   <= w_req_mmio;
            if (w_fault) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_fault <= 1'b1;
              r_rsp_cause <= w_cause;
            end else begin
              r_state <= S_ACCESS;
              r_cnt   <= CW'(WAIT_CYCLES);
            end
          end
        end
        S_ACCESS: begin
          if (w_last) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_we ? 32'h0 : w_ext;
            r_rsp_fault <= 1'b0;
            r_rsp_cause <= '0;
`ifdef MEM_BUS_MMIO_EN
            if (r_we && r_mmio) r_led <= r_wdata[7:0];
`endif
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_fault <= 1'b0;
          r_rsp_cause <= '0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;
  assign rsp_cause = r_rsp_cause;

endmodule
